// File: rtl/regb_ops.sv
// Purpose: bank of NREGS WIDTH-bit registers with load, in-place INC/DEC/SHL/SHR/ROL/ROR/CLR,
//          and shared registered zero/carry flags.
// Latency: writes visible one edge later; ALU/DOUT/BUSEN reads are combinational (0 cycles).
// Backpressure: none; every edge accepts a load or op, and back-to-back ops on one register chain.
//
// Ports:
//   CLK   - clock; all state updates on rising edge
//   nRST  - synchronous active-low reset (regs=0, ZF=1, CF=0); beats load/op
//   SEL   - target index for load, op and DOUT
//   ASEL  - index presented on ALU
//   nLd   - 0 = load DBUS into reg[SEL]; takes priority over OP
//   OP    - in-place op on reg[SEL] when nLd=1
//   nEo   - 0 = drive reg[SEL] on DOUT
//   DBUS  - data bus input
//   ALU   - reg[ASEL]
//   DOUT  - reg[SEL] when nEo=0, else zero
//   BUSEN - ~nEo, for the top-level bus mux
//   ZF/CF - registered zero and carry/borrow/shifted-out flags from the last write
module regb_ops #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [$clog2(NREGS)-1:0] SEL,
  input  logic [$clog2(NREGS)-1:0] ASEL,
  input  logic                     nLd,
  input  logic [2:0]               OP,
  input  logic                     nEo,
  input  logic [WIDTH-1:0]         DBUS,
  output logic [WIDTH-1:0]         ALU,
  output logic [WIDTH-1:0]         DOUT,
  output logic                     BUSEN,
  output logic                     ZF,
  output logic                     CF
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic             zf_q;
  logic             cf_q;

  logic [WIDTH-1:0] cur_v;
  logic [WIDTH-1:0] wdat_d;
  logic             wr_en_d;
  logic             cf_d;

  assign cur_v = regs_q[SEL];

  // Next value for reg[SEL] and the carry it produces. HOLD leaves wr_en_d low,
  // which also keeps both flags untouched.
  always_comb begin
    wr_en_d = 1'b0;
    wdat_d  = cur_v;
    cf_d    = cf_q;
    if (!nLd) begin
      wr_en_d = 1'b1;
      wdat_d  = DBUS;
      cf_d    = 1'b0;
    end else begin
      unique case (OP)
        OP_HOLD: begin
          wr_en_d = 1'b0;
        end
        OP_INC: begin
          wr_en_d = 1'b1;
          wdat_d  = cur_v + 1'b1;
          cf_d    = &cur_v;
        end
        OP_DEC: begin
          wr_en_d = 1'b1;
          wdat_d  = cur_v - 1'b1;
          cf_d    = (cur_v == '0);
        end
        OP_SHL: begin
          wr_en_d = 1'b1;
          wdat_d  = {cur_v[WIDTH-2:0], 1'b0};
          cf_d    = cur_v[WIDTH-1];
        end
        OP_SHR: begin
          wr_en_d = 1'b1;
          wdat_d  = {1'b0, cur_v[WIDTH-1:1]};
          cf_d    = cur_v[0];
        end
        OP_ROL: begin
          wr_en_d = 1'b1;
          wdat_d  = {cur_v[WIDTH-2:0], cur_v[WIDTH-1]};
          cf_d    = cur_v[WIDTH-1];
        end
        OP_ROR: begin
          wr_en_d = 1'b1;
          wdat_d  = {cur_v[0], cur_v[WIDTH-1:1]};
          cf_d    = cur_v[0];
        end
        OP_CLR: begin
          wr_en_d = 1'b1;
          wdat_d  = '0;
          cf_d    = 1'b0;
        end
        default: begin
          wr_en_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      zf_q <= 1'b1;
      cf_q <= 1'b0;
    end else if (wr_en_d) begin
      regs_q[SEL] <= wdat_d;
      zf_q        <= (wdat_d == '0);
      cf_q        <= cf_d;
    end
  end

  assign ALU   = regs_q[ASEL];
  assign DOUT  = nEo ? '0 : cur_v;
  assign BUSEN = ~nEo;
  assign ZF    = zf_q;
  assign CF    = cf_q;

endmodule

// File: tb/tb_regb_ops.sv
// Purpose: directed-vector bench for regb_ops; driver queues expected outputs, monitor compares.
// Latency: each vector is checked at the falling edge of the cycle in which it is driven.
// Backpressure: none; the monitor drains at most one expectation per cycle.
module tb_regb_ops;

  localparam logic [2:0] HOLD = 3'b000;
  localparam logic [2:0] INC  = 3'b001;
  localparam logic [2:0] DEC  = 3'b010;
  localparam logic [2:0] SHL  = 3'b011;
  localparam logic [2:0] SHR  = 3'b100;
  localparam logic [2:0] ROL  = 3'b101;
  localparam logic [2:0] ROR  = 3'b110;
  localparam logic [2:0] CLR  = 3'b111;

  logic       clk;
  logic       n_rst;
  logic [1:0] sel;
  logic [1:0] asel;
  logic       n_ld;
  logic [2:0] op;
  logic       n_eo;
  logic [7:0] dbus;
  logic [7:0] alu;
  logic [7:0] dout;
  logic       busen;
  logic       zf;
  logic       cf;

  typedef struct {
    string      name;
    logic [7:0] alu;
    logic [7:0] dout;
    logic       busen;
    logic       zf;
    logic       cf;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  regb_ops #(.WIDTH(8), .NREGS(4)) dut (
    .CLK   (clk),
    .nRST  (n_rst),
    .SEL   (sel),
    .ASEL  (asel),
    .nLd   (n_ld),
    .OP    (op),
    .nEo   (n_eo),
    .DBUS  (dbus),
    .ALU   (alu),
    .DOUT  (dout),
    .BUSEN (busen),
    .ZF    (zf),
    .CF    (cf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are combinational on the inputs driven this cycle, so
  // the falling edge is a stable point to compare against the queued vector.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_vec++;
      if (alu !== e.alu || dout !== e.dout || busen !== e.busen || zf !== e.zf || cf !== e.cf) begin
        n_fail++;
        $display("FAIL %s: got ALU=%02h DOUT=%02h BUSEN=%b ZF=%b CF=%b, want ALU=%02h DOUT=%02h BUSEN=%b ZF=%b CF=%b",
                 e.name, alu, dout, busen, zf, cf, e.alu, e.dout, e.busen, e.zf, e.cf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [1:0] s, input logic [1:0] a, input logic l,
                       input logic [2:0] o, input logic eo, input logic [7:0] d);
    n_rst = r; sel = s; asel = a; n_ld = l; op = o; n_eo = eo; dbus = d;
  endtask

  task automatic expect_now(input string nm, input logic [7:0] ea, input logic [7:0] ed,
                            input logic eb, input logic ez, input logic ec);
    exp_t e;
    e.name = nm; e.alu = ea; e.dout = ed; e.busen = eb; e.zf = ez; e.cf = ec;
    sb_q.push_back(e);
  endtask

  initial begin
    drive(1'b1, 2'd0, 2'd0, 1'b1, HOLD, 1'b1, 8'h00);

    // Reset with a load and an op pending: reset must win.
    tick(); drive(1'b0, 2'd0, 2'd0, 1'b0, INC, 1'b1, 8'hA5);
    tick(); drive(1'b1, 2'd0, 2'd0, 1'b1, HOLD, 1'b1, 8'h00); expect_now("rst_r0", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); drive(1'b1, 2'd0, 2'd1, 1'b1, HOLD, 1'b1, 8'h00); expect_now("rst_r1", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); drive(1'b1, 2'd0, 2'd2, 1'b1, HOLD, 1'b1, 8'h00); expect_now("rst_r2", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); drive(1'b1, 2'd0, 2'd3, 1'b1, HOLD, 1'b1, 8'h00); expect_now("rst_r3", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // Loads on consecutive edges; each check reads the register loaded one edge earlier.
    tick(); drive(1'b1, 2'd0, 2'd3, 1'b0, HOLD, 1'b1, 8'h11); expect_now("ld_pre",  8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); drive(1'b1, 2'd1, 2'd0, 1'b0, HOLD, 1'b1, 8'h22); expect_now("ld_r0",   8'h11, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); drive(1'b1, 2'd2, 2'd1, 1'b0, HOLD, 1'b1, 8'h33); expect_now("ld_r1",   8'h22, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); drive(1'b1, 2'd3, 2'd2, 1'b0, HOLD, 1'b1, 8'h44); expect_now("ld_r2",   8'h33, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); drive(1'b1, 2'd0, 2'd3, 1'b1, HOLD, 1'b1, 8'h00); expect_now("ld_r3",   8'h44, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); drive(1'b1, 2'd0, 2'd0, 1'b1, HOLD, 1'b1, 8'h00); expect_now("iso_r0",  8'h11, 8'h00, 1'b0, 1'b0, 1'b0);

    // INC/DEC wrap on r2, ops chained back to back.
    tick(); drive(1'b1, 2'd2, 2'd2, 1'b0, HOLD, 1'b1, 8'hFF); expect_now("ld_ff_old", 8'h33, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); drive(1'b1, 2'd2, 2'd2, 1'b1, INC,  1'b1, 8'h00); expect_now("ld_ff",     8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); drive(1'b1, 2'd2, 2'd2, 1'b1, DEC,  1'b1, 8'h00); expect_now("inc_wrap",  8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    tick(); drive(1'b1, 2'd2, 2'd2, 1'b1, DEC,  1'b1, 8'h00); expect_now("dec_wrap",  8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    tick(); drive(1'b1, 2'd2, 2'd2, 1'b1, HOLD, 1'b1, 8'h00); expect_now("dec_plain", 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0);

    // Shifts and rotates on r1 = 0x81.
    tick(); drive(1'b1, 2'd1, 2'd1, 1'b0, HOLD, 1'b1, 8'h81); expect_now("ld81_old", 8'h22, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); drive(1'b1, 2'd1, 2'd1, 1'b1, SHL,  1'b1, 8'h00); expect_now("ld81",     8'h81, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); drive(1'b1, 2'd1, 2'd1, 1'b1, SHR,  1'b1, 8'h00); expect_now("shl",      8'h02, 8'h00, 1'b0, 1'b0, 1'b1);
    tick(); drive(1'b1, 2'd1, 2'd1, 1'b1, ROR,  1'b1, 8'h00); expect_now("shr",      8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); drive(1'b1, 2'd1, 2'd1, 1'b1, ROL,  1'b1, 8'h00); expect_now("ror",      8'h80, 8'h00, 1'b0, 1'b0, 1'b1);
    tick(); drive(1'b1, 2'd1, 2'd1, 1'b1, HOLD, 1'b1, 8'h00); expect_now("rol",      8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
    tick(); drive(1'b1, 2'd1, 2'd1, 1'b1, HOLD, 1'b1, 8'h00); expect_now("hold_flg", 8'h01, 8'h00, 1'b0, 1'b0, 1'b1);

    // Load beats op; CLR touches only its target.
    tick(); drive(1'b1, 2'd3, 2'd3, 1'b0, INC,  1'b1, 8'h00); expect_now("prio_old", 8'h44, 8'h00, 1'b0, 1'b0, 1'b1);
    tick(); drive(1'b1, 2'd0, 2'd3, 1'b0, HOLD, 1'b1, 8'h55); expect_now("prio_ld",  8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); drive(1'b1, 2'd0, 2'd0, 1'b1, CLR,  1'b1, 8'h00); expect_now("ld55",     8'h55, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); drive(1'b1, 2'd0, 2'd0, 1'b1, HOLD, 1'b1, 8'h00); expect_now("clr",      8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); drive(1'b1, 2'd0, 2'd1, 1'b1, HOLD, 1'b1, 8'h00); expect_now("clr_r1",   8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); drive(1'b1, 2'd0, 2'd2, 1'b1, HOLD, 1'b1, 8'h00); expect_now("clr_r2",   8'hFE, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); drive(1'b1, 2'd0, 2'd3, 1'b1, HOLD, 1'b1, 8'h00); expect_now("clr_r3",   8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // Bus output with a simultaneous load to the same register.
    tick(); drive(1'b1, 2'd1, 2'd1, 1'b0, HOLD, 1'b1, 8'h22); expect_now("ld22_old", 8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); drive(1'b1, 2'd1, 2'd1, 1'b0, HOLD, 1'b0, 8'h99); expect_now("bus_pre",  8'h22, 8'h22, 1'b1, 1'b0, 1'b0);
    tick(); drive(1'b1, 2'd1, 2'd1, 1'b1, HOLD, 1'b0, 8'h00); expect_now("bus_post", 8'h99, 8'h99, 1'b1, 1'b0, 1'b0);
    tick(); drive(1'b1, 2'd1, 2'd1, 1'b1, HOLD, 1'b1, 8'h00); expect_now("bus_off",  8'h99, 8'h00, 1'b0, 1'b0, 1'b0);

    // Mid-run reset clears everything; BUSEN still follows nEo.
    tick(); drive(1'b0, 2'd1, 2'd1, 1'b0, DEC,  1'b1, 8'hA5); expect_now("rst2_pre", 8'h99, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); drive(1'b1, 2'd1, 2'd1, 1'b1, HOLD, 1'b0, 8'h00); expect_now("rst2",     8'h00, 8'h00, 1'b1, 1'b1, 1'b0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(posedge clk);
    end
    @(posedge clk);
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench still running at %0t, want finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
